// File: rtl/intr_ctrl_v1_pkg.sv
// Shared types for intr_ctrl_v1: SFR field layouts and the request FSM state encoding.
package intr_ctrl_v1_pkg;

    localparam int unsigned SFR_W = 32;

    typedef struct packed {
        logic [SFR_W-3:0] rsvd;
        logic             act;
        logic             gie;
    } intr_ctrl_t;

    typedef logic [SFR_W-1:0] intr_en_t;
    typedef logic [SFR_W-1:0] intr_prio_t;
    typedef logic [SFR_W-1:0] intr_pend_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } intr_state_t;

endpackage

// File: rtl/intr_ctrl_v1_prio_arb.sv
// Combinational priority arbiter: highest priority candidate wins, ties go to the lowest index.
module intr_prio_arb
    import intr_ctrl_v1_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = 2,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_SRC-1:0]        cand_i,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
    output logic [ID_W-1:0]           win_id_o,
    output logic [PRIO_W-1:0]         win_prio_o,
    output logic                      win_valid_o
);

    logic [ID_W-1:0]   best_id_s;
    logic [PRIO_W-1:0] best_prio_s;
    logic              best_valid_s;

    // Ascending scan with a strict compare keeps the lowest index on equal priority.
    always_comb begin
        best_id_s    = '0;
        best_prio_s  = '0;
        best_valid_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand_i[i] && (!best_valid_s || (prio_i[i*PRIO_W +: PRIO_W] > best_prio_s))) begin
                best_id_s    = ID_W'(i);
                best_prio_s  = prio_i[i*PRIO_W +: PRIO_W];
                best_valid_s = 1'b1;
            end else begin
                best_valid_s = best_valid_s;
            end
        end
    end

    assign win_id_o    = best_id_s;
    assign win_prio_o  = best_prio_s;
    assign win_valid_o = best_valid_s;

endmodule

// File: rtl/intr_ctrl_v1.sv
// Interrupt controller top: event edge detect, pending flags, arbitration and req/ack/done FSM.
// Define INTR_PREEMPT_EN to allow one level of nesting by a strictly higher priority source.
module intr_ctrl_v1
    import intr_ctrl_v1_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned NUM_SRC    = 8,
    parameter  int unsigned PRIO_W     = 2,
    localparam int unsigned ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [NUM_SRC-1:0]    src_event,
    input  logic [DATA_WIDTH-1:0] intr_ctrl,
    input  logic [DATA_WIDTH-1:0] intr_en,
    input  logic [DATA_WIDTH-1:0] intr_prio,
    input  logic [NUM_SRC-1:0]    intr_pend_clr,
    input  logic                  irq_ack,
    input  logic                  irq_done,
    output logic                  irq_req,
    output logic [ID_W-1:0]       irq_id,
    output logic [DATA_WIDTH-1:0] hw_up_intr_pend,
    output logic [DATA_WIDTH-1:0] hw_val_intr_pend,
    output logic [DATA_WIDTH-1:0] hw_up_intr_ctrl,
    output logic [DATA_WIDTH-1:0] hw_val_intr_ctrl
);

    logic [NUM_SRC-1:0]    src_dly_q, pend_q, pend_d;
    logic [NUM_SRC-1:0]    rise_s, ack_vec_s, clr_s, cand_s;
    logic [ID_W-1:0]       win_id_s;
    logic [PRIO_W-1:0]     win_prio_s;
    logic                  win_valid_s, req_valid_s, take_ack_s;
    logic                  preempt_s, nest_req_s, gie_s, unused_s;
    logic [DATA_WIDTH-1:0] hw_up_pend_q, hw_val_pend_q, hw_up_ctrl_q, hw_val_ctrl_q;
    intr_state_t           state_q, state_d;
    intr_ctrl_t            ctrl_up_s, ctrl_val_s;

    assign gie_s    = intr_ctrl[0];
    assign unused_s = ^{intr_ctrl[DATA_WIDTH-1:1], intr_en, intr_prio, win_prio_s};
    assign rise_s   = src_event & ~src_dly_q;
    assign cand_s   = pend_q & intr_en[NUM_SRC-1:0] & {NUM_SRC{gie_s}};
    assign clr_s    = intr_pend_clr | ack_vec_s;
    assign pend_d   = (pend_q & ~clr_s) | rise_s;

    intr_prio_arb #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_arb (
        .cand_i      (cand_s),
        .prio_i      (intr_prio[NUM_SRC*PRIO_W-1:0]),
        .win_id_o    (win_id_s),
        .win_prio_o  (win_prio_s),
        .win_valid_o (win_valid_s)
    );

`ifdef INTR_PREEMPT_EN
    logic [ID_W-1:0]   act_id_q, act_id_d, save_id_q, save_id_d;
    logic [PRIO_W-1:0] act_prio_q, act_prio_d, save_prio_q, save_prio_d;
    logic              save_vld_q, save_vld_d, nest_req_q, nest_req_d;

    assign nest_req_s  = nest_req_q;
    assign req_valid_s = win_valid_s && (!nest_req_q || (win_prio_s > act_prio_q));
    assign preempt_s   = !save_vld_q && win_valid_s && (win_prio_s > act_prio_q);
`else
    assign nest_req_s  = 1'b0;
    assign req_valid_s = win_valid_s;
    assign preempt_s   = 1'b0;
`endif

    // Request FSM next state; a withdrawn nested request falls back to the interrupted handler.
    always_comb begin
        state_d    = state_q;
        take_ack_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid_s) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (!req_valid_s) begin
                    state_d = nest_req_s ? ACTIVE : IDLE;
                end else if (irq_ack) begin
                    take_ack_s = 1'b1;
                    state_d    = ACTIVE;
                end else begin
                    state_d = REQ;
                end
            end
            ACTIVE: begin
                if (irq_done) begin
`ifdef INTR_PREEMPT_EN
                    state_d = save_vld_q ? ACTIVE : IDLE;
`else
                    state_d = IDLE;
`endif
                end else if (preempt_s) begin
                    state_d = REQ;
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One-hot clear of the acknowledged source.
    always_comb begin
        ack_vec_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_vec_s[i] = take_ack_s && (win_id_s == ID_W'(i));
        end
    end

    // Status mirror for the ctrl SFR: act is rewritten every cycle.
    always_comb begin
        ctrl_up_s      = '0;
        ctrl_up_s.act  = 1'b1;
        ctrl_val_s     = '0;
        ctrl_val_s.act = (state_d == ACTIVE);
    end

    // Core state and registered SFR update strobes.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            src_dly_q     <= '0;
            pend_q        <= '0;
            hw_up_pend_q  <= '0;
            hw_val_pend_q <= '0;
            hw_up_ctrl_q  <= '0;
            hw_val_ctrl_q <= '0;
        end else begin
            state_q       <= state_d;
            src_dly_q     <= src_event;
            pend_q        <= pend_d;
            hw_up_pend_q  <= DATA_WIDTH'(rise_s | clr_s);
            hw_val_pend_q <= DATA_WIDTH'(pend_d);
            hw_up_ctrl_q  <= DATA_WIDTH'(ctrl_up_s);
            hw_val_ctrl_q <= DATA_WIDTH'(ctrl_val_s);
        end
    end

`ifdef INTR_PREEMPT_EN
    // Active context: capture on ack, push the outer handler when nesting, pop on its done.
    always_comb begin
        act_id_d    = act_id_q;
        act_prio_d  = act_prio_q;
        save_id_d   = save_id_q;
        save_prio_d = save_prio_q;
        save_vld_d  = save_vld_q;
        nest_req_d  = (state_d == REQ) && ((state_q == ACTIVE) || ((state_q == REQ) && nest_req_q));
        if (take_ack_s) begin
            act_id_d   = win_id_s;
            act_prio_d = win_prio_s;
            if (nest_req_q) begin
                save_id_d   = act_id_q;
                save_prio_d = act_prio_q;
                save_vld_d  = 1'b1;
            end else begin
                save_vld_d  = save_vld_q;
            end
        end else if ((state_q == ACTIVE) && irq_done && save_vld_q) begin
            act_id_d   = save_id_q;
            act_prio_d = save_prio_q;
            save_vld_d = 1'b0;
        end else begin
            save_vld_d = save_vld_q;
        end
    end

    // Nesting context registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            act_id_q    <= '0;
            act_prio_q  <= '0;
            save_id_q   <= '0;
            save_prio_q <= '0;
            save_vld_q  <= 1'b0;
            nest_req_q  <= 1'b0;
        end else begin
            act_id_q    <= act_id_d;
            act_prio_q  <= act_prio_d;
            save_id_q   <= save_id_d;
            save_prio_q <= save_prio_d;
            save_vld_q  <= save_vld_d;
            nest_req_q  <= nest_req_d;
        end
    end
`endif

    assign irq_req          = (state_q == REQ);
    assign irq_id           = (state_q == REQ) ? win_id_s : '0;
    assign hw_up_intr_pend  = hw_up_pend_q;
    assign hw_val_intr_pend = hw_val_pend_q;
    assign hw_up_intr_ctrl  = hw_up_ctrl_q;
    assign hw_val_intr_ctrl = hw_val_ctrl_q;

endmodule

// File: tb/tb_intr_ctrl_v1.sv
// Self-checking bench for intr_ctrl_v1: directed scenarios plus randomized traffic against a reference model.
module tb_intr_ctrl_v1;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  src_event = 8'h00;
    logic [31:0] intr_ctrl = 32'h0, intr_en = 32'h0, intr_prio = 32'h0;
    logic [7:0]  intr_pend_clr = 8'h00;
    logic        irq_ack = 1'b0, irq_done = 1'b0;
    logic        irq_req;
    logic [2:0]  irq_id;
    logic [31:0] hw_up_intr_pend, hw_val_intr_pend, hw_up_intr_ctrl, hw_val_intr_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef INTR_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    intr_ctrl_v1 dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .src_event        (src_event),
        .intr_ctrl        (intr_ctrl),
        .intr_en          (intr_en),
        .intr_prio        (intr_prio),
        .intr_pend_clr    (intr_pend_clr),
        .irq_ack          (irq_ack),
        .irq_done         (irq_done),
        .irq_req          (irq_req),
        .irq_id           (irq_id),
        .hw_up_intr_pend  (hw_up_intr_pend),
        .hw_val_intr_pend (hw_val_intr_pend),
        .hw_up_intr_ctrl  (hw_up_intr_ctrl),
        .hw_val_intr_ctrl (hw_val_intr_ctrl)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference state: mode 0 idle, 1 requesting, 2 handler running.
    typedef struct packed {
        logic [7:0]  pend;
        logic [7:0]  prev_ev;
        logic [1:0]  mode;
        logic        nested;
        logic [2:0]  act_id;
        logic [1:0]  act_prio;
        logic        sv;
        logic [2:0]  sid;
        logic [1:0]  sprio;
        logic [31:0] up_pend;
        logic [31:0] val_pend;
        logic [31:0] up_ctrl;
        logic [31:0] val_ctrl;
    } mdl_t;

    mdl_t m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Winner = maximum of (priority, reversed index) score among enabled pending sources.
    function automatic void pick(input logic [7:0] pend, input logic [31:0] ctrl, input logic [31:0] en,
                                 input logic [31:0] prio, output bit vld, output int id, output int pr);
        int best;
        best = -1; id = 0; pr = 0; vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int p;
            int score;
            p = int'(prio[2*i +: 2]);
            score = p * 8 + (7 - i);
            if (pend[i] && en[i] && ctrl[0] && score > best) begin
                best = score; id = i; pr = p; vld = 1'b1;
            end
        end
    endfunction

    function automatic mdl_t model_step(input mdl_t cur, input logic [7:0] ev, input logic [7:0] clr,
                                        input logic [31:0] ctrl, input logic [31:0] en, input logic [31:0] prio,
                                        input logic ack, input logic done);
        mdl_t n;
        bit wv;
        int wid;
        int wpr;
        bit taken;
        logic [7:0] rise;
        logic [7:0] ackv;
        n = cur;
        taken = 1'b0;
        pick(cur.pend, ctrl, en, prio, wv, wid, wpr);
        rise = ev & ~cur.prev_ev;
        case (cur.mode)
            2'd0: if (wv) begin n.mode = 2'd1; n.nested = 1'b0; end
            2'd1: begin
                if (!(wv && (!cur.nested || wpr > int'(cur.act_prio)))) n.mode = cur.nested ? 2'd2 : 2'd0;
                else if (ack) begin
                    taken = 1'b1; n.mode = 2'd2;
                    if (cur.nested) begin n.sv = 1'b1; n.sid = cur.act_id; n.sprio = cur.act_prio; end
                    n.act_id = 3'(wid); n.act_prio = 2'(wpr);
                end
            end
            default: begin
                if (done) begin
                    if (cur.sv) begin n.sv = 1'b0; n.act_id = cur.sid; n.act_prio = cur.sprio; end
                    else n.mode = 2'd0;
                end else if (PREEMPT && !cur.sv && wv && wpr > int'(cur.act_prio)) begin
                    n.mode = 2'd1; n.nested = 1'b1;
                end
            end
        endcase
        ackv = taken ? 8'(1 << wid) : 8'h00;
        n.prev_ev  = ev;
        n.pend     = rise | (cur.pend & ~clr & ~ackv);
        n.up_pend  = {24'd0, rise | clr | ackv};
        n.val_pend = {24'd0, n.pend};
        n.up_ctrl  = 32'd2;
        n.val_ctrl = (n.mode == 2'd2) ? 32'd2 : 32'd0;
        return n;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) m <= '0;
        else m <= model_step(m, src_event, intr_pend_clr, intr_ctrl, intr_en, intr_prio, irq_ack, irq_done);
    end

    always @(negedge sys_clk) begin : cmp_proc
        bit v;
        int id;
        int pr;
        pick(m.pend, intr_ctrl, intr_en, intr_prio, v, id, pr);
        chk("irq_req", 32'(irq_req), 32'(m.mode == 2'd1));
        chk("irq_id", 32'(irq_id), (m.mode == 2'd1) ? 32'(id) : 32'd0);
        chk("hw_up_pend", hw_up_intr_pend, m.up_pend);
        chk("hw_val_pend", hw_val_intr_pend, m.val_pend);
        chk("hw_up_ctrl", hw_up_intr_ctrl, m.up_ctrl);
        chk("hw_val_ctrl", hw_val_intr_ctrl, m.val_ctrl);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain();
        src_event = 8'h00; irq_ack = 1'b0;
        intr_pend_clr = 8'hFF; irq_done = 1'b1;
        tick(); tick();
        intr_pend_clr = 8'h00; irq_done = 1'b0;
        tick();
    endtask

    initial begin
        #12;
        chk("rst_irq_req", 32'(irq_req), 32'd0);
        chk("rst_up_ctrl", hw_up_intr_ctrl, 32'd0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        tick();
        chk("first_up_ctrl", hw_up_intr_ctrl, 32'd2);

        // Held event level -> one pending set, request two edges after the rise.
        intr_ctrl = 32'd1; intr_en = 32'h08; intr_prio = 32'd0;
        src_event = 8'h08; tick();
        chk("s1_up3", hw_up_intr_pend, 32'h08);
        chk("s1_req_early", 32'(irq_req), 32'd0);
        tick();
        chk("s1_req", 32'(irq_req), 32'd1);
        chk("s1_id", 32'(irq_id), 32'd3);
        tick(); tick(); tick();
        src_event = 8'h00;
        chk("s1_no_rerise", hw_up_intr_pend, 32'h00);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("s1_ack_pend", hw_val_intr_pend, 32'h00);
        chk("s1_act", hw_val_intr_ctrl, 32'd2);
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        chk("s1_idle", hw_val_intr_ctrl, 32'd0);
        drain();

        // Priority ordering and tie break.
        intr_en = 32'hFF; intr_prio = 32'h0000_0C04;
        src_event = 8'h22; tick(); src_event = 8'h00; tick();
        chk("s2_id5", 32'(irq_id), 32'd5);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("s2_pend_after_ack", hw_val_intr_pend, 32'h02);
        irq_done = 1'b1; tick(); irq_done = 1'b0; tick();
        chk("s2_req1", 32'(irq_req), 32'd1);
        chk("s2_id1", 32'(irq_id), 32'd1);
        drain();
        intr_prio = 32'h0000_2020;
        src_event = 8'h44; tick(); src_event = 8'h00; tick();
        chk("s2_tie", 32'(irq_id), 32'd2);
        drain();

        // Set wins over a simultaneous clear.
        intr_ctrl = 32'd0;
        src_event = 8'h10; tick(); src_event = 8'h00; tick();
        src_event = 8'h10; intr_pend_clr = 8'h10; tick();
        chk("s3_up", hw_up_intr_pend, 32'h10);
        chk("s3_val", hw_val_intr_pend, 32'h10);
        intr_pend_clr = 8'h00; src_event = 8'h00;
        drain();

        // Withdraw on disable.
        intr_ctrl = 32'd1; intr_en = 32'h01; intr_prio = 32'd0;
        src_event = 8'h01; tick(); src_event = 8'h00; tick();
        chk("s4_req", 32'(irq_req), 32'd1);
        intr_en = 32'h00; tick();
        chk("s4_withdraw", 32'(irq_req), 32'd0);
        chk("s4_pend_kept", hw_val_intr_pend, 32'h01);
        drain();

        // Higher priority event during a handler.
        intr_en = 32'hFF; intr_prio = 32'h0000_C010;
        src_event = 8'h04; tick(); src_event = 8'h00; tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        src_event = 8'h80; tick(); src_event = 8'h00; tick();
`ifdef INTR_PREEMPT_EN
        chk("s5_nest_req", 32'(irq_req), 32'd1);
        chk("s5_nest_id", 32'(irq_id), 32'd7);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        chk("s5_restored_act", hw_val_intr_ctrl, 32'd2);
        tick();
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        chk("s5_outer_done", hw_val_intr_ctrl, 32'd0);
`else
        chk("s5_no_preempt", 32'(irq_req), 32'd0);
        irq_done = 1'b1; tick(); irq_done = 1'b0; tick();
        chk("s5_req7", 32'(irq_req), 32'd1);
        chk("s5_id7", 32'(irq_id), 32'd7);
`endif
        drain();

        // Asynchronous reset while a handler runs with pending A5.
        intr_en = 32'h01; intr_prio = 32'd0;
        src_event = 8'hA5; tick(); src_event = 8'h00; tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        src_event = 8'h01; tick(); src_event = 8'h00;
        chk("s6_pre_pend", hw_val_intr_pend, 32'hA5);
        chk("s6_pre_act", hw_val_intr_ctrl, 32'd2);
        sys_rst_n = 1'b0; #1;
        chk("s6_rst_req", 32'(irq_req), 32'd0);
        chk("s6_rst_pend", hw_val_intr_pend, 32'd0);
        chk("s6_rst_ctrl", hw_val_intr_ctrl | hw_up_intr_ctrl | hw_up_intr_pend, 32'd0);
        tick(); sys_rst_n = 1'b1; tick();
        chk("s6_post_pend", hw_val_intr_pend, 32'd0);

        // Randomized traffic checked every cycle by cmp_proc.
        intr_en = 32'hFF;
        for (int c = 0; c < 2000; c++) begin
            src_event = 8'($urandom) & 8'($urandom);
            intr_pend_clr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 15) == 0) intr_en = {24'($urandom), 8'($urandom)};
            if ($urandom_range(0, 31) == 0) intr_prio = $urandom;
            intr_ctrl = {31'($urandom), ($urandom_range(0, 9) != 0)};
            irq_ack  = ($urandom_range(0, 2) == 0);
            irq_done = ($urandom_range(0, 3) == 0);
            if (c == 1000) begin
                sys_rst_n = 1'b0; tick(); sys_rst_n = 1'b1;
            end
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
